// File: rtl/proc_n.sv
// Multi-cycle processor: eight GPRs, accumulator A, result G and a 9-bit IR on one shared bus.
// Instructions take one cycle after fetch (mv, mvi, mvnz) or three (ALU ops).
module proc_n #(
  parameter int unsigned DATA_W = 9
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] Bus,
  output logic              Done
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] OpMv   = 3'b000;
  localparam logic [2:0] OpMvi  = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpSub  = 3'b011;
  localparam logic [2:0] OpAnd  = 3'b100;
  localparam logic [2:0] OpOr   = 3'b101;
  localparam logic [2:0] OpXor  = 3'b110;
  localparam logic [2:0] OpMvnz = 3'b111;

  logic [1:0]        state_q, state_d;
  logic [8:0]        ir_q;
  logic [DATA_W-1:0] r_q [8];
  logic [DATA_W-1:0] a_q, g_q;
  logic [DATA_W-1:0] alu_res;
  logic [2:0]        op, rx, ry;
  logic              is_alu;
  logic              ir_we, a_we, g_we, rx_we;

  assign op     = ir_q[8:6];
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];
  assign is_alu = (op >= OpAdd) && (op != OpMvnz);

  always_comb begin
    Bus = '0;
    case (state_q)
      T1: begin
        if (is_alu)            Bus = r_q[rx];
        else if (op == OpMvi)  Bus = DIN;
        else                   Bus = r_q[ry];
      end
      T2:      Bus = r_q[ry];
      T3:      Bus = g_q;
      default: Bus = '0;
    endcase
  end

  always_comb begin
    alu_res = a_q;
    case (op)
      OpAdd:   alu_res = a_q + Bus;
      OpSub:   alu_res = a_q - Bus;
      OpAnd:   alu_res = a_q & Bus;
      OpOr:    alu_res = a_q | Bus;
      OpXor:   alu_res = a_q ^ Bus;
      default: alu_res = a_q;
    endcase
  end

  always_comb begin
    state_d = T0;
    Done    = 1'b0;
    ir_we   = 1'b0;
    a_we    = 1'b0;
    g_we    = 1'b0;
    rx_we   = 1'b0;
    case (state_q)
      T0: begin
        if (Run) begin
          ir_we   = 1'b1;
          state_d = T1;
        end else begin
          state_d = T0;
        end
      end
      T1: begin
        if (is_alu) begin
          a_we    = 1'b1;
          state_d = T2;
        end else begin
          Done    = 1'b1;
          // mvnz looks at G from before this instruction; G is not written here
          rx_we   = (op != OpMvnz) || (g_q != '0);
          state_d = T0;
        end
      end
      T2: begin
        g_we    = 1'b1;
        state_d = T3;
      end
      T3: begin
        Done    = 1'b1;
        rx_we   = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (ir_we) ir_q <= DIN[8:0];
      if (a_we)  a_q  <= Bus;
      if (g_we)  g_q  <= alu_res;
      if (rx_we) r_q[rx] <= Bus;
    end
  end

endmodule
